// File: rtl/led_sched_pkg.sv
// ============================================================================
//  Module   : led_sched_pkg
//  Purpose  : Shared types and constants for the LED step scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_sched_pkg;

    typedef enum logic [1:0] {
        KEY_IDLE     = 2'd0,
        KEY_DEBOUNCE = 2'd1,
        KEY_HELD     = 2'd2,
        KEY_REPEAT   = 2'd3
    } key_state_e;

    localparam int REQ_IDX_W = 2;
    localparam int NUM_REQ   = 3;

    localparam logic [REQ_IDX_W-1:0] REQ_INC  = 2'd0;
    localparam logic [REQ_IDX_W-1:0] REQ_DEC  = 2'd1;
    localparam logic [REQ_IDX_W-1:0] REQ_AUTO = 2'd2;

    localparam int POS_W    = 3;
    localparam int NUM_LEDS = 8;

    // Round-robin successor: inc -> dec -> auto -> inc.
    function automatic logic [REQ_IDX_W-1:0] rr_next(input logic [REQ_IDX_W-1:0] idx);
        return (idx == REQ_AUTO) ? REQ_INC : idx + 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_step_scheduler_key_repeat.sv
// ============================================================================
//  Module   : key_repeat
//  Purpose  : Key synchroniser, debounce and hold-to-repeat FSM; one-cycle req.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_repeat
    import led_sched_pkg::*;
#(
    parameter int DEB_CYCLES    = 50000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n_i,
    output logic req_o,
    output logic idle_o
);

    localparam int MAX_CYC_A = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYC   = (MAX_CYC_A > REPEAT_CYCLES) ? MAX_CYC_A : REPEAT_CYCLES;
    localparam int CNT_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic [1:0]       sync_q;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pressed;

    assign pressed = ~sync_q[1];
    assign idle_o  = (state_q == KEY_IDLE);

    // Sync flops reset to "released" so a key held across reset re-debounces.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q  <= 2'b11;
            state_q <= KEY_IDLE;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], key_n_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_o   = 1'b0;
        case (state_q)
            KEY_IDLE: begin
                cnt_d = '0;
                if (pressed) state_d = KEY_DEBOUNCE;
            end
            KEY_DEBOUNCE: begin
                if (!pressed) begin
                    state_d = KEY_IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = KEY_HELD;
                    cnt_d   = '0;
                    req_o   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            KEY_HELD: begin
                if (!pressed) begin
                    state_d = KEY_IDLE;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = KEY_REPEAT;
                    cnt_d   = '0;
                    req_o   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            KEY_REPEAT: begin
                if (!pressed) begin
                    state_d = KEY_IDLE;
                end else if (cnt_q == REP_LAST) begin
                    cnt_d = '0;
                    req_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = KEY_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/led_step_scheduler.sv
// ============================================================================
//  Module   : led_step_scheduler
//  Purpose  : Arbitrates inc/dec keys and auto-sweep onto a one-hot LED position.
//             Define LED_SCHED_SATURATE_EN to make manual steps saturate at 0/7.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_step_scheduler
    import led_sched_pkg::*;
#(
    parameter int DEB_CYCLES    = 50000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int AUTO_PERIOD   = 12500000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_inc_n,
    input  logic                key_dec_n,
    input  logic                auto_en,
    output logic                step_valid,
    output logic                step_dir,
    output logic [POS_W-1:0]    pos,
    output logic [NUM_LEDS-1:0] LEDS
);

    localparam int                AUTO_W    = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);
    localparam logic [POS_W-1:0]  POS_MAX   = POS_W'(NUM_LEDS - 1);

    logic inc_req, dec_req, inc_idle, dec_idle;

    key_repeat #(
        .DEB_CYCLES    (DEB_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_key_inc (
        .clk     (clk),
        .reset   (reset),
        .key_n_i (key_inc_n),
        .req_o   (inc_req),
        .idle_o  (inc_idle)
    );

    key_repeat #(
        .DEB_CYCLES    (DEB_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_key_dec (
        .clk     (clk),
        .reset   (reset),
        .key_n_i (key_dec_n),
        .req_o   (dec_req),
        .idle_o  (dec_idle)
    );

    logic [AUTO_W-1:0]    auto_cnt_q, auto_cnt_d;
    logic                 auto_run, auto_req;
    logic [NUM_REQ-1:0]   pend_q, pend_d, req_vec, grant;
    logic [REQ_IDX_W-1:0] rr_q, rr_d, grant_idx;
    logic                 grant_any;
    logic [2:0]           cand;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic                 step_valid_q, step_valid_d;
    logic                 step_dir_q, step_dir_d;
    logic                 sweep_up_q, sweep_up_d;

    assign auto_run = auto_en & inc_idle & dec_idle;
    assign auto_req = auto_run && (auto_cnt_q == AUTO_LAST);

    always_comb begin
        auto_cnt_d = auto_cnt_q + 1'b1;
        if (!auto_run || auto_req) auto_cnt_d = '0;
    end

    // A request landing on an already-set flag is dropped, even in its grant cycle.
    assign req_vec = {auto_req, dec_req, inc_req};
    assign pend_d  = (pend_q & ~grant) | (~pend_q & req_vec);

    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = rr_q;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_q} + 3'(k);
            if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
            if (!grant_any && pend_q[cand[1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[1:0];
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
        rr_d = grant_any ? rr_next(grant_idx) : rr_q;
    end

    always_comb begin
        pos_d        = pos_q;
        step_dir_d   = step_dir_q;
        step_valid_d = 1'b0;
        sweep_up_d   = sweep_up_q;
        if (grant_any) begin
            case (grant_idx)
                REQ_INC: begin
`ifdef LED_SCHED_SATURATE_EN
                    if (pos_q != POS_MAX) begin
                        pos_d        = pos_q + 1'b1;
                        step_dir_d   = 1'b1;
                        step_valid_d = 1'b1;
                    end
`else
                    pos_d        = pos_q + 1'b1;
                    step_dir_d   = 1'b1;
                    step_valid_d = 1'b1;
`endif
                end
                REQ_DEC: begin
`ifdef LED_SCHED_SATURATE_EN
                    if (pos_q != '0) begin
                        pos_d        = pos_q - 1'b1;
                        step_dir_d   = 1'b0;
                        step_valid_d = 1'b1;
                    end
`else
                    pos_d        = pos_q - 1'b1;
                    step_dir_d   = 1'b0;
                    step_valid_d = 1'b1;
`endif
                end
                default: begin
                    // Ping-pong: the turn at an end happens within the same step.
                    step_valid_d = 1'b1;
                    if (pos_q == POS_MAX) begin
                        sweep_up_d = 1'b0;
                    end else if (pos_q == '0) begin
                        sweep_up_d = 1'b1;
                    end
                    if ((pos_q != POS_MAX) && ((pos_q == '0) || sweep_up_q)) begin
                        pos_d      = pos_q + 1'b1;
                        step_dir_d = 1'b1;
                    end else begin
                        pos_d      = pos_q - 1'b1;
                        step_dir_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            auto_cnt_q   <= '0;
            pend_q       <= '0;
            rr_q         <= REQ_INC;
            pos_q        <= '0;
            step_valid_q <= 1'b0;
            step_dir_q   <= 1'b1;
            sweep_up_q   <= 1'b1;
        end else begin
            auto_cnt_q   <= auto_cnt_d;
            pend_q       <= pend_d;
            rr_q         <= rr_d;
            pos_q        <= pos_d;
            step_valid_q <= step_valid_d;
            step_dir_q   <= step_dir_d;
            sweep_up_q   <= sweep_up_d;
        end
    end

    assign pos        = pos_q;
    assign step_valid = step_valid_q;
    assign step_dir   = step_dir_q;
    assign LEDS       = NUM_LEDS'(1) << pos_q;

endmodule

`default_nettype wire

// File: tb/tb_led_step_scheduler.sv
// ============================================================================
//  Module   : tb_led_step_scheduler
//  Purpose  : Directed self-checking bench for led_step_scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_step_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_inc_n = 1'b1;
    logic       key_dec_n = 1'b1;
    logic       auto_en = 1'b0;
    logic       step_valid;
    logic       step_dir;
    logic [2:0] pos;
    logic [7:0] LEDS;

    led_step_scheduler #(
        .DEB_CYCLES    (4),
        .HOLD_CYCLES   (20),
        .REPEAT_CYCLES (8),
        .AUTO_PERIOD   (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_inc_n  (key_inc_n),
        .key_dec_n  (key_dec_n),
        .auto_en    (auto_en),
        .step_valid (step_valid),
        .step_dir   (step_dir),
        .pos        (pos),
        .LEDS       (LEDS)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [2:0] pos;
        logic       dir;
        logic [7:0] leds;
    } step_t;

    step_t steps[$];

    always @(negedge clk) begin
        if (step_valid === 1'b1) steps.push_back('{cyc, pos, step_dir, LEDS});
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        steps.delete();
    endtask

    task automatic press(input bit inc);
        if (inc) key_inc_n = 1'b0; else key_dec_n = 1'b0;
        tick(10);
        key_inc_n = 1'b1;
        key_dec_n = 1'b1;
        tick(8);
    endtask

    task automatic chk_step(input string name, input int k, input int exp_cyc,
                            input logic [2:0] exp_pos, input logic exp_dir);
        if (k >= steps.size()) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: step %0d missing, got %0d steps", name, k, steps.size());
        end else begin
            chk({name, "_cyc"},  steps[k].cyc,  exp_cyc);
            chk({name, "_pos"},  {29'd0, steps[k].pos}, {29'd0, exp_pos});
            chk({name, "_dir"},  {31'd0, steps[k].dir}, {31'd0, exp_dir});
            chk({name, "_leds"}, {24'd0, steps[k].leds}, 32'd1 << exp_pos);
        end
    endtask

    typedef struct {
        bit         inc;
        logic [2:0] exp_pos;
        logic       exp_dir;
        int         exp_steps;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int t0;
        int nv;

        // Single presses from pos 0, including the 0 -> 7 and 7 -> 0 boundaries.
        vecs[0] = '{1'b1, 3'd1, 1'b1, 1};
        vecs[1] = '{1'b1, 3'd2, 1'b1, 1};
        vecs[2] = '{1'b0, 3'd1, 1'b0, 1};
        vecs[3] = '{1'b0, 3'd0, 1'b0, 1};
`ifdef LED_SCHED_SATURATE_EN
        vecs[4] = '{1'b0, 3'd0, 1'b0, 0};
        vecs[5] = '{1'b1, 3'd1, 1'b1, 1};
`else
        vecs[4] = '{1'b0, 3'd7, 1'b0, 1};
        vecs[5] = '{1'b1, 3'd0, 1'b1, 1};
`endif
        nv = 6;

        // Reset state
        do_reset();
        chk("rst_pos",   {29'd0, pos}, 32'd0);
        chk("rst_leds",  {24'd0, LEDS}, 32'h01);
        chk("rst_valid", {31'd0, step_valid}, 32'd0);
        chk("rst_dir",   {31'd0, step_dir}, 32'd1);

        // Table-driven single presses
        for (int i = 0; i < nv; i++) begin
            steps.delete();
            press(vecs[i].inc);
            chk($sformatf("tbl%0d_steps", i), steps.size(), vecs[i].exp_steps);
            chk($sformatf("tbl%0d_pos", i),  {29'd0, pos}, {29'd0, vecs[i].exp_pos});
            chk($sformatf("tbl%0d_leds", i), {24'd0, LEDS}, 32'd1 << vecs[i].exp_pos);
            chk($sformatf("tbl%0d_dir", i),  {31'd0, step_dir}, {31'd0, vecs[i].exp_dir});
        end

        // Bounce: 2-cycle pulses never pass debounce; final hold gives one step
        do_reset();
        for (int i = 0; i < 5; i++) begin
            key_inc_n = 1'b0;
            tick(2);
            key_inc_n = 1'b1;
            tick(2);
        end
        key_inc_n = 1'b0;
        t0 = cyc;
        tick(12);
        key_inc_n = 1'b1;
        tick(8);
        chk("bounce_steps", steps.size(), 1);
        chk_step("bounce", 0, t0 + 8, 3'd1, 1'b1);

        // Key held through reset must debounce again after release
        key_inc_n = 1'b0;
        do_reset();
        t0 = cyc;
        tick(12);
        key_inc_n = 1'b1;
        tick(8);
        chk("rsthold_steps", steps.size(), 1);
        chk_step("rsthold", 0, t0 + 8, 3'd1, 1'b1);

        // Hold-repeat on dec from pos 0
        do_reset();
        key_dec_n = 1'b0;
        t0 = cyc;
        tick(60);
        key_dec_n = 1'b1;
        tick(10);
`ifdef LED_SCHED_SATURATE_EN
        chk("hold_steps", steps.size(), 0);
        chk("hold_pos", {29'd0, pos}, 32'd0);
`else
        chk("hold_steps", steps.size(), 6);
        chk_step("hold0", 0, t0 + 8,  3'd7, 1'b0);
        chk_step("hold1", 1, t0 + 28, 3'd6, 1'b0);
        chk_step("hold2", 2, t0 + 36, 3'd5, 1'b0);
        chk_step("hold3", 3, t0 + 44, 3'd4, 1'b0);
        chk_step("hold4", 4, t0 + 52, 3'd3, 1'b0);
        chk_step("hold5", 5, t0 + 60, 3'd2, 1'b0);
`endif

        // Simultaneous press: inc wins, dec follows next cycle
        do_reset();
        key_inc_n = 1'b0;
        key_dec_n = 1'b0;
        t0 = cyc;
        tick(12);
        key_inc_n = 1'b1;
        key_dec_n = 1'b1;
        tick(8);
        chk("simul_steps", steps.size(), 2);
        chk_step("simul0", 0, t0 + 8, 3'd1, 1'b1);
        chk_step("simul1", 1, t0 + 9, 3'd0, 1'b0);

        // Auto sweep from pos 5: 6, 7, 6, 5
        do_reset();
        for (int i = 0; i < 5; i++) press(1'b1);
        chk("auto_start_pos", {29'd0, pos}, 32'd5);
        steps.delete();
        auto_en = 1'b1;
        t0 = cyc;
        tick(70);
        auto_en = 1'b0;
        tick(4);
        chk("auto_steps", steps.size(), 4);
        chk_step("auto0", 0, t0 + 17, 3'd6, 1'b1);
        chk_step("auto1", 1, t0 + 33, 3'd7, 1'b1);
        chk_step("auto2", 2, t0 + 49, 3'd6, 1'b0);
        chk_step("auto3", 3, t0 + 65, 3'd5, 1'b0);

        // Manual step at pos 7: wrap or saturate, then a dec press
        do_reset();
        for (int i = 0; i < 7; i++) press(1'b1);
        chk("top_start_pos", {29'd0, pos}, 32'd7);
        steps.delete();
        press(1'b1);
`ifdef LED_SCHED_SATURATE_EN
        chk("top_inc_steps", steps.size(), 0);
        chk("top_inc_pos", {29'd0, pos}, 32'd7);
        steps.delete();
        press(1'b0);
        chk("top_dec_steps", steps.size(), 1);
        chk_step("top_dec", 0, steps.size() > 0 ? steps[0].cyc : -1, 3'd6, 1'b0);
`else
        chk("top_inc_steps", steps.size(), 1);
        chk("top_inc_pos", {29'd0, pos}, 32'd0);
        chk("top_inc_dir", {31'd0, step_dir}, 32'd1);
        steps.delete();
        press(1'b0);
        chk("top_dec_steps", steps.size(), 1);
        chk("top_dec_pos", {29'd0, pos}, 32'd7);
        chk("top_dec_leds", {24'd0, LEDS}, 32'h80);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
